nvme_admin_sq_fetch: RTL and testbench
======================================

# nvme_admin_sq_fetch

Admin Submission Queue fetch engine for the NVMe controller. It sits directly downstream of the controller register block and consumes its CC.EN, ASQ base address and AQA.ASQS outputs. It tracks the SQ0 tail doorbell and head pointer, and issues 64-byte memory reads for each pending admin command. It assembles each command from 32-bit read beats and presents it to the admin command decoder with a valid/ready handshake.

## Interface
- Clocking/reset: one clock; reset is asynchronous and active-high.
- QPTR_W, default 12: width of the queue head/tail pointers (matches AQA.ASQS).
- clk  in  1  controller clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  CC.EN from the register block; low = queue disabled.
- asq_base  in  64  ASQ base address; bits [11:0] ignored (treated as 0).
- asqs  in  QPTR_W  AQA.ASQS, zero-based queue size (entries = asqs+1).
- db_wr  in  1  one-cycle strobe: host write to the SQ0 tail doorbell.
- db_data  in  16  new tail value carried by the doorbell write.
- db_err  out  1  one-cycle pulse: rejected doorbell value.
- rd_req_valid  out  1  memory read request valid (64 bytes).
- rd_req_ready  in  1  memory read request accepted.
- rd_req_addr  out  64  byte address of the requested entry.
- rd_data_valid  in  1  read data beat valid (no backpressure).
- rd_data  in  32  read data beat, dword order, lowest dword first.
- cmd_valid  out  1  assembled command valid.
- cmd_ready  in  1  decoder accepts the command.
- cmd_data  out  512  command; dword k in [32k+31:32k].
- sq_head  out  QPTR_W  current SQ head pointer (for completion SQHD).
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, REQ, DATA, OUT, DRAIN. Moore outputs, decoded from the registered state.
- IDLE -> REQ when en=1 and head!=tail.
- REQ: rd_req_valid=1, rd_req_addr={asq_base[63:12],12'h000} + head*64. On a valid&&ready handshake: beat counter=0, go to DATA.
- DATA: each rd_data_valid writes rd_data into cmd_data dword[beat] and increments beat. After the 16th beat, go to OUT.
- OUT: cmd_valid=1. On cmd_valid&&cmd_ready: head <= (head==asqs) ? 0 : head+1, go to IDLE.
- Doorbell, when en=1: if db_data > {zero-extended asqs}, db_err pulses and tail is unchanged. Otherwise tail <= db_data[QPTR_W-1:0]. When en=0, doorbell writes are ignored and db_err is not raised.
- Empty is head==tail. Full is not tracked; overfilling the queue is the host's responsibility.
- en deasserted:
  - head and tail clear to 0.
  - REQ and OUT go to IDLE immediately; any pending request or command is dropped.
  - DATA goes to DRAIN. DRAIN discards the remaining beats until 16 have been counted, then goes to IDLE. cmd_valid is never raised for that command.
- A doorbell write in the same cycle as a head advance: both updates take effect.
- rd_data_valid outside DATA/DRAIN is ignored.

## Timing
- Reset values: all outputs 0 (rd_req_addr, cmd_data, sq_head = 0; db_err, rd_req_valid, cmd_valid, busy = 0). head=tail=0, state=IDLE, beat=0.
- Doorbell sampled at edge E: tail updates at E, state=REQ at E+1, so rd_req_valid is high from E+1.
- rd_req_addr is stable while rd_req_valid is high. cmd_data is stable while cmd_valid is high.
- The 16th beat at edge F gives cmd_valid high from F.
- Head advances at the cmd handshake edge, and sq_head reflects it immediately. IDLE re-evaluates on the next cycle, so back-to-back commands have 1 idle cycle between handshake and the next rd_req_valid.
- db_err is registered: high for exactly one cycle after the offending db_wr edge.
- Address arithmetic is 64-bit; head*64 = {head,6'b0}, so there is no overflow for QPTR_W=12.

## Test plan
- en=1, asq_base=0x0000_1000, asqs=3, doorbell 1 -> one request at 0x1000; beats 0..15 -> cmd_data dword k = k; after the handshake, sq_head=1 and busy=0.
- Wrap: doorbell 3, consume three commands, then doorbell 0 -> fourth request at 0x10C0; head goes 3->0 after the handshake; no further requests.
- Doorbell 4 with asqs=3 -> db_err high exactly one cycle, tail unchanged, no request.
- Backpressure: rd_req_ready low for 5 cycles -> rd_req_addr stable, one request only; cmd_ready low for 10 cycles -> cmd_data stable, sq_head unchanged.
- en dropped after 5 data beats -> busy stays high through 11 more beats, cmd_valid never asserts, then IDLE with sq_head=0; a doorbell write while en=0 is ignored with db_err=0.
- Async reset asserted in REQ, between clock edges -> rd_req_valid, busy and sq_head go to 0 immediately; after release, no request until a new doorbell write.

Source files
------------

// File: rtl/nvme_admin_sq_fetch.sv
// Admin submission queue fetch engine: tracks the SQ0 tail doorbell and head,
// reads one 64-byte entry per pending command and hands it to the decoder.
module nvme_admin_sq_fetch #(
    parameter int QPTR_W = 12
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic [63:0]       asq_base_i,
    input  logic [QPTR_W-1:0] asqs_i,
    input  logic              db_wr_i,
    input  logic [15:0]       db_data_i,
    output logic              db_err_o,
    output logic              rd_req_valid_o,
    input  logic              rd_req_ready_i,
    output logic [63:0]       rd_req_addr_o,
    input  logic              rd_data_valid_i,
    input  logic [31:0]       rd_data_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [511:0]      cmd_data_o,
    output logic [QPTR_W-1:0] sq_head_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t            state_q;
    logic [3:0]        beat_q;
    logic [QPTR_W-1:0] head_q, head_d;
    logic [QPTR_W-1:0] tail_q, tail_d;
    logic [63:0]       addr_q;
    logic              db_err_q;
    logic [31:0]       dword_q [16];

    logic              db_hit;
    logic              db_bad;
    logic              cmd_fire;
    logic              beat_fire;
    logic [63:0]       base_aligned;
    logic [63:0]       head_off;

    assign db_hit       = en_i && db_wr_i;
    assign db_bad       = db_hit && (32'(db_data_i) > 32'(asqs_i));
    assign cmd_fire     = en_i && (state_q == ST_OUT) && cmd_ready_i;
    assign beat_fire    = rd_data_valid_i && ((state_q == ST_DATA) || (state_q == ST_DRAIN));
    assign base_aligned = asq_base_i & ~64'hFFF;
    assign head_off     = {{(58-QPTR_W){1'b0}}, head_q, 6'b000000};

    // A doorbell and a head advance in the same cycle both land.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (!en_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (cmd_fire)
                head_d = (head_q == asqs_i) ? '0 : head_q + QPTR_W'(1);
            if (db_hit && !db_bad)
                tail_d = db_data_i[QPTR_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            addr_q   <= '0;
            db_err_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            db_err_q <= db_bad;
            case (state_q)
                ST_IDLE: begin
                    if (en_i && (head_q != tail_q)) begin
                        state_q <= ST_REQ;
                        addr_q  <= base_aligned + head_off;
                    end
                end
                ST_REQ: begin
                    if (!en_i) begin
                        state_q <= ST_IDLE;
                    end else if (rd_req_ready_i) begin
                        beat_q  <= '0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        beat_q <= beat_q + 4'd1;
                        if (beat_q == 4'd15)
                            state_q <= en_i ? ST_OUT : ST_IDLE;
                        else if (!en_i)
                            state_q <= ST_DRAIN;
                    end else if (!en_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_OUT: begin
                    if (!en_i || cmd_ready_i)
                        state_q <= ST_IDLE;
                end
                ST_DRAIN: begin
                    // The read is still in flight; swallow its beats before reuse.
                    if (beat_fire) begin
                        beat_q <= beat_q + 4'd1;
                        if (beat_q == 4'd15)
                            state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_dword
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i)
                    dword_q[gi] <= '0;
                else if (en_i && (state_q == ST_DATA) && rd_data_valid_i && (beat_q == 4'(gi)))
                    dword_q[gi] <= rd_data_i;
            end
            assign cmd_data_o[32*gi +: 32] = dword_q[gi];
        end
    endgenerate

    assign rd_req_valid_o = (state_q == ST_REQ);
    assign cmd_valid_o    = (state_q == ST_OUT);
    assign busy_o         = (state_q != ST_IDLE);
    assign rd_req_addr_o  = addr_q;
    assign sq_head_o      = head_q;
    assign db_err_o       = db_err_q;

endmodule

// File: tb/tb_nvme_admin_sq_fetch.sv
// Bench for nvme_admin_sq_fetch: doorbell vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level queue model.
module tb_nvme_admin_sq_fetch;
    localparam int QW = 12;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           en = 1'b0;
    logic [63:0]    asq_base = '0;
    logic [QW-1:0]  asqs = '0;
    logic           db_wr = 1'b0;
    logic [15:0]    db_data = '0;
    logic           db_err;
    logic           rd_req_valid;
    logic           rd_req_ready = 1'b0;
    logic [63:0]    rd_req_addr;
    logic           rd_data_valid = 1'b0;
    logic [31:0]    rd_data = '0;
    logic           cmd_valid;
    logic           cmd_ready = 1'b0;
    logic [511:0]   cmd_data;
    logic [QW-1:0]  sq_head;
    logic           busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nvme_admin_sq_fetch #(.QPTR_W(QW)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .asq_base_i(asq_base), .asqs_i(asqs),
        .db_wr_i(db_wr), .db_data_i(db_data), .db_err_o(db_err),
        .rd_req_valid_o(rd_req_valid), .rd_req_ready_i(rd_req_ready), .rd_req_addr_o(rd_req_addr),
        .rd_data_valid_i(rd_data_valid), .rd_data_i(rd_data),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_data_o(cmd_data),
        .sq_head_o(sq_head), .busy_o(busy)
    );

    typedef struct {
        logic [15:0]   db;
        logic          err;
        int            ncmd;
        logic [63:0]   addr0;
        logic [QW-1:0] head_end;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_db(input logic [15:0] v);
        db_wr   = 1'b1;
        db_data = v;
        step();
        db_wr   = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a, input int k);
        return a[31:0] ^ (32'(k) * 32'h9E3779B1);
    endfunction

    function automatic logic [511:0] mem_cmd(input logic [63:0] a);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = mem_word(a, k);
        return r;
    endfunction

    function automatic logic [511:0] tag_cmd(input int tag);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = 32'(k) | (32'(tag) << 16);
        return r;
    endfunction

    function automatic logic [QW-1:0] next_head(input logic [63:0] a);
        logic [QW-1:0] h;
        h = QW'((a - (asq_base & ~64'hFFF)) >> 6);
        return (h == asqs) ? '0 : h + QW'(1);
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!rd_req_valid && n < 50) begin
            step();
            n++;
        end
        check("req_seen", 512'(rd_req_valid), 512'(1));
    endtask

    task automatic send_beats(input int first, input int cnt, input int tag);
        for (int k = first; k < first + cnt; k++) begin
            rd_data_valid = 1'b1;
            rd_data       = 32'(k) | (32'(tag) << 16);
            step();
        end
        rd_data_valid = 1'b0;
    endtask

    task automatic serve_cmd(input logic [63:0] exp_addr, input int tag);
        wait_req();
        check("req_addr", 512'(rd_req_addr), 512'(exp_addr));
        rd_req_ready = 1'b1;
        step();
        rd_req_ready = 1'b0;
        send_beats(0, 16, tag);
        check("cmd_valid_on_16th", 512'(cmd_valid), 512'(1));
        check("cmd_data", cmd_data, tag_cmd(tag));
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("sq_head_after_hs", 512'(sq_head), 512'(next_head(exp_addr)));
        check("cmd_valid_dropped", 512'(cmd_valid), 512'(0));
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic seen = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            step();
            seen = seen | rd_req_valid;
        end
        check(name, 512'(seen), 512'(0));
    endtask

    initial begin
        logic [QW-1:0] mh, mt;
        logic          mem_act, exp_err, obs_req, obs_cmd, hs_req, hs_cmd, beat_now;
        logic [63:0]   mem_addr, req_addr;
        int            beats;

        vecs[0] = '{16'd1,      1'b0, 1, 64'h1000, 12'd1};
        vecs[1] = '{16'd3,      1'b0, 2, 64'h1040, 12'd3};
        vecs[2] = '{16'd0,      1'b0, 1, 64'h10C0, 12'd0};
        vecs[3] = '{16'd4,      1'b1, 0, 64'h0,    12'd0};
        vecs[4] = '{16'd2,      1'b0, 2, 64'h1000, 12'd2};
        vecs[5] = '{16'hFFFF,   1'b1, 0, 64'h0,    12'd2};

        // Reset state
        step();
        check("rst_rd_req_valid", 512'(rd_req_valid), 512'(0));
        check("rst_rd_req_addr", 512'(rd_req_addr), 512'(0));
        check("rst_cmd_valid", 512'(cmd_valid), 512'(0));
        check("rst_cmd_data", cmd_data, 512'(0));
        check("rst_sq_head", 512'(sq_head), 512'(0));
        check("rst_busy_err", 512'({busy, db_err}), 512'(0));
        reset    = 1'b0;
        en       = 1'b1;
        asq_base = 64'h0000_0000_0000_1000;
        asqs     = QW'(3);
        step();

        // Doorbell vector table
        for (int i = 0; i < 6; i++) begin
            drive_db(vecs[i].db);
            check("db_err_pulse", 512'(db_err), 512'(vecs[i].err));
            step();
            check("db_err_one_cycle", 512'(db_err), 512'(0));
            check("req_at_e_plus_1", 512'(rd_req_valid), 512'(vecs[i].ncmd > 0));
            for (int j = 0; j < vecs[i].ncmd; j++)
                serve_cmd(vecs[i].addr0 + 64'(64 * j), i * 4 + j);
            expect_quiet("no_extra_req", 8);
            check("vec_busy_idle", 512'(busy), 512'(0));
            check("vec_head_end", 512'(sq_head), 512'(vecs[i].head_end));
        end

        // Backpressure on request and command (head 2 -> 3)
        drive_db(16'd3);
        step();
        for (int n = 0; n < 5; n++) begin
            check("bp_req_valid", 512'(rd_req_valid), 512'(1));
            check("bp_req_addr", 512'(rd_req_addr), 512'(64'h1080));
            step();
        end
        rd_req_ready = 1'b1;
        step();
        rd_req_ready = 1'b0;
        check("bp_single_req", 512'(rd_req_valid), 512'(0));
        send_beats(0, 16, 77);
        for (int n = 0; n < 10; n++) begin
            check("bp_cmd_valid", 512'(cmd_valid), 512'(1));
            check("bp_cmd_data", cmd_data, tag_cmd(77));
            check("bp_sq_head", 512'(sq_head), 512'(2));
            step();
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check("bp_head_adv", 512'(sq_head), 512'(3));

        // en dropped mid-burst: drain, drop command, ignore doorbell
        drive_db(16'd0);
        step();
        check("drop_req_addr", 512'(rd_req_addr), 512'(64'h10C0));
        rd_req_ready = 1'b1;
        step();
        rd_req_ready = 1'b0;
        send_beats(0, 5, 88);
        en = 1'b0;
        step();
        check("drop_busy", 512'(busy), 512'(1));
        check("drop_head_clr", 512'(sq_head), 512'(0));
        for (int k = 0; k < 11; k++) begin
            rd_data_valid = 1'b1;
            rd_data       = 32'(k);
            if (k == 2) begin
                db_wr   = 1'b1;
                db_data = 16'd9;
            end
            step();
            db_wr = 1'b0;
            check("drain_busy", 512'(busy), 512'(k < 10));
            check("drain_no_cmd", 512'(cmd_valid), 512'(0));
            check("drain_no_err", 512'(db_err), 512'(0));
        end
        rd_data_valid = 1'b0;
        en = 1'b1;
        expect_quiet("drop_no_req", 10);
        check("drop_head_zero", 512'(sq_head), 512'(0));

        // Asynchronous reset while in REQ
        drive_db(16'd1);
        serve_cmd(64'h1000, 90);
        drive_db(16'd2);
        step();
        check("ar_in_req", 512'(rd_req_valid), 512'(1));
        #3 reset = 1'b1;
        #1;
        check("ar_req_valid", 512'(rd_req_valid), 512'(0));
        check("ar_busy", 512'(busy), 512'(0));
        check("ar_sq_head", 512'(sq_head), 512'(0));
        step();
        step();
        reset = 1'b0;
        expect_quiet("ar_no_req", 10);
        drive_db(16'd1);
        step();
        serve_cmd(64'h1000, 91);

        // Randomized traffic against a queue model (head=tail=1 here)
        mh       = QW'(1);
        mt       = QW'(1);
        asqs     = QW'(7);
        asq_base = {$urandom, $urandom};
        mem_act  = 1'b0;
        mem_addr = '0;
        req_addr = '0;
        beats    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            obs_req       = rd_req_valid;
            obs_cmd       = cmd_valid;
            rd_req_ready  = ($urandom % 3) != 0;
            cmd_ready     = ($urandom % 3) != 0;
            beat_now      = mem_act && (($urandom % 4) != 0);
            rd_data_valid = beat_now;
            rd_data       = beat_now ? mem_word(mem_addr, beats) : $urandom;
            db_wr         = 1'b0;
            exp_err       = 1'b0;
            if (cyc < 2500 && ($urandom % 10) == 0) begin
                db_wr   = 1'b1;
                db_data = 16'($urandom_range(0, 9));
                if (db_data > 16'(asqs)) exp_err = 1'b1;
                else mt = db_data[QW-1:0];
            end
            hs_req = obs_req && rd_req_ready;
            hs_cmd = obs_cmd && cmd_ready;
            if (hs_req) begin
                req_addr = (asq_base & ~64'hFFF) + 64'(mh) * 64;
                check("rnd_req_addr", 512'(rd_req_addr), 512'(req_addr));
            end
            if (hs_cmd) check("rnd_cmd_data", cmd_data, mem_cmd(mem_addr));
            step();
            db_wr = 1'b0;
            check("rnd_db_err", 512'(db_err), 512'(exp_err));
            if (beat_now) begin
                beats++;
                if (beats == 16) mem_act = 1'b0;
            end
            if (hs_req) begin
                mem_act  = 1'b1;
                mem_addr = req_addr;
                beats    = 0;
            end
            if (hs_cmd) begin
                mh = (mh == asqs) ? '0 : mh + QW'(1);
                check("rnd_sq_head", 512'(sq_head), 512'(mh));
            end
        end
        rd_req_ready  = 1'b0;
        cmd_ready     = 1'b0;
        rd_data_valid = 1'b0;
        check("rnd_final_busy", 512'(busy), 512'(0));
        check("rnd_final_head", 512'(sq_head), 512'(mt));
        check("rnd_final_req", 512'(rd_req_valid), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
